// File: rtl/exec_dispatch_pkg.sv
// Shared constants for the execution-unit dispatch path: destination-type codes
// and the dispatcher state encoding.
package exec_dispatch_pkg;

    localparam int DST_TYPE_WIDTH = 2;

    localparam logic [DST_TYPE_WIDTH-1:0] DST_NONE = 2'd0;
    localparam logic [DST_TYPE_WIDTH-1:0] DST_RD   = 2'd1;
    localparam logic [DST_TYPE_WIDTH-1:0] DST_RT   = 2'd2;
    localparam logic [DST_TYPE_WIDTH-1:0] DST_RA   = 2'd3;

    localparam logic [4:0] RA_ADDR = 5'd31;

    typedef enum logic [2:0] {
        DSP_IDLE  = 3'd0,
        DSP_EXEC  = 3'd1,
        DSP_WB    = 3'd2,
        DSP_FLUSH = 3'd3,
        DSP_ERR   = 3'd4
    } dsp_state_e;

endpackage

// File: rtl/exec_dispatch_if.sv
// Enable/finished handshake plus result bus between the dispatcher and one
// execution unit.
interface exec_dispatch_if;
    import exec_dispatch_pkg::*;

    logic                      exec_en;
    logic                      exec_finished;
    logic [31:0]               exec_res;
    logic [DST_TYPE_WIDTH-1:0] exec_dst_type;

    modport master (
        output exec_en,
        input  exec_finished,
        input  exec_res,
        input  exec_dst_type
    );

    modport slave (
        input  exec_en,
        output exec_finished,
        output exec_res,
        output exec_dst_type
    );

endinterface

// File: rtl/exec_dispatch_dst_addr_sel.sv
// Resolves the register-file write address from the unit's destination type and
// the instruction's rt/rd fields; writes to r0 are suppressed.
module dst_addr_sel
    import exec_dispatch_pkg::*;
(
    input  logic [DST_TYPE_WIDTH-1:0] dst_type,
    input  logic [4:0]                rt,
    input  logic [4:0]                rd,
    output logic [4:0]                waddr,
    output logic                      we_ok
);

    always_comb begin
        waddr = 5'd0;
        case (dst_type)
            DST_RD:  waddr = rd;
            DST_RT:  waddr = rt;
            DST_RA:  waddr = RA_ADDR;
            default: waddr = 5'd0;
        endcase
        we_ok = (dst_type != DST_NONE) && (waddr != 5'd0);
    end

endmodule

// File: rtl/exec_dispatch.sv
// Initiator side of the execution-unit handshake: launches one instruction,
// waits for the unit, writes the result back and guards against a hung unit.
module exec_dispatch
    import exec_dispatch_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic                  clk,
    input  logic                  clrn,
    input  logic                  start,
    input  logic [4:0]            rt_addr,
    input  logic [4:0]            rd_addr,
    exec_dispatch_if.master       eu,
    output logic                  rf_we,
    output logic [4:0]            rf_waddr,
    output logic [31:0]           rf_wdata,
    output logic                  done,
    output logic                  busy,
    output logic                  err
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(TIMEOUT);

    dsp_state_e        state_q, state_d;
    logic [4:0]        rt_q, rt_d;
    logic [4:0]        rd_q, rd_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              rf_we_q, rf_we_d;
    logic              done_q, done_d;
    logic [4:0]        rf_waddr_q, rf_waddr_d;
    logic [31:0]       rf_wdata_q, rf_wdata_d;

    logic [4:0]        sel_waddr;
    logic              sel_we_ok;

    dst_addr_sel u_dst_addr_sel (
        .dst_type (eu.exec_dst_type),
        .rt       (rt_q),
        .rd       (rd_q),
        .waddr    (sel_waddr),
        .we_ok    (sel_we_ok)
    );

    always_comb begin
        state_d    = state_q;
        rt_d       = rt_q;
        rd_d       = rd_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        rf_we_d    = 1'b0;
        done_d     = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;

        case (state_q)
            DSP_IDLE: begin
                if (start) begin
                    rt_d    = rt_addr;
                    rd_d    = rd_addr;
                    cnt_d   = '0;
                    state_d = DSP_EXEC;
                end
            end
            DSP_EXEC: begin
                if (cnt_q != CNT_SAT) begin
                    cnt_d = cnt_q + 1'b1;
                end
                // Write-back registers load on the way into WB so they are
                // valid for exactly the WB cycle and hold afterwards.
                if (eu.exec_finished) begin
                    rf_wdata_d = eu.exec_res;
                    rf_waddr_d = sel_waddr;
                    rf_we_d    = sel_we_ok;
                    done_d     = 1'b1;
                    state_d    = DSP_WB;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = DSP_ERR;
                end
            end
            DSP_WB: begin
                state_d = DSP_FLUSH;
            end
            DSP_FLUSH: begin
                // The unit drops finished one edge after en falls.
                if (!eu.exec_finished) begin
                    state_d = DSP_IDLE;
                end
            end
            DSP_ERR: begin
                state_d = DSP_ERR;
            end
            default: begin
                state_d = DSP_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q    <= DSP_IDLE;
            rt_q       <= 5'd0;
            rd_q       <= 5'd0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            rf_we_q    <= 1'b0;
            done_q     <= 1'b0;
            rf_waddr_q <= 5'd0;
            rf_wdata_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            rt_q       <= rt_d;
            rd_q       <= rd_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            rf_we_q    <= rf_we_d;
            done_q     <= done_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    assign eu.exec_en = (state_q == DSP_EXEC);
    assign busy       = (state_q != DSP_IDLE);
    assign err        = err_q;
    assign rf_we      = rf_we_q;
    assign done       = done_q;
    assign rf_waddr   = rf_waddr_q;
    assign rf_wdata   = rf_wdata_q;

endmodule

// File: tb/tb_exec_dispatch.sv
// Directed bench for exec_dispatch: the write-back scoreboard is filled as each
// instruction is issued and drained by a monitor on every done pulse.
module tb_exec_dispatch;
    import exec_dispatch_pkg::*;

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
    } wb_t;

    logic        clk = 1'b0;
    logic        clrn;
    logic        start;
    logic [4:0]  rt_addr;
    logic [4:0]  rd_addr;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        done;
    logic        busy;
    logic        err;

    int checks = 0;
    int errors = 0;
    wb_t sb_q[$];

    exec_dispatch_if eu ();

    exec_dispatch #(.TIMEOUT(64), .CNT_W(7)) dut (
        .clk      (clk),
        .clrn     (clrn),
        .start    (start),
        .rt_addr  (rt_addr),
        .rd_addr  (rd_addr),
        .eu       (eu),
        .rf_we    (rf_we),
        .rf_waddr (rf_waddr),
        .rf_wdata (rf_wdata),
        .done     (done),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic wb_t expect_wb(input logic [4:0] rt, input logic [4:0] rd,
                                      input logic [31:0] res, input logic [1:0] dst);
        wb_t e;
        e.data = res;
        e.addr = 5'd0;
        if (dst == DST_RD)      e.addr = rd;
        else if (dst == DST_RT) e.addr = rt;
        else if (dst == DST_RA) e.addr = 5'd31;
        e.we = (dst != DST_NONE) && (e.addr != 5'd0);
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding write-back.
    always @(negedge clk) begin
        wb_t e;
        if (clrn === 1'b1) begin
            chk1("we_without_done", rf_we & ~done, 1'b0);
            if (done === 1'b1) begin
                chk1("sb_nonempty", sb_q.size() != 0, 1'b1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    chk1("wb_we", rf_we, e.we);
                    if (e.we) begin
                        chk32("wb_addr", {27'd0, rf_waddr}, {27'd0, e.addr});
                        chk32("wb_data", rf_wdata, e.data);
                    end
                    $display("WB we=%b addr=%0d data=%h", rf_we, rf_waddr, rf_wdata);
                end
            end
        end
    end

    // Issue one instruction; the unit raises finished after `delay` EXEC cycles.
    task automatic do_instr(input logic [4:0] rt, input logic [4:0] rd, input int delay,
                            input logic [31:0] res, input logic [1:0] dst);
        $display("INSTR rt=%0d rd=%0d dst=%0d res=%h delay=%0d", rt, rd, dst, res, delay);
        sb_q.push_back(expect_wb(rt, rd, res, dst));
        rt_addr = rt;
        rd_addr = rd;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        for (int i = 0; i < delay; i++) begin
            chk1("exec_en_wait", eu.exec_en, 1'b1);
            chk1("busy_exec", busy, 1'b1);
            tick();
        end
        eu.exec_finished = 1'b1;
        eu.exec_res      = res;
        eu.exec_dst_type = dst;
        chk1("exec_en_fin", eu.exec_en, 1'b1);
        tick();
        chk1("done_wb", done, 1'b1);
        chk1("exec_en_wb", eu.exec_en, 1'b0);
        tick();
        eu.exec_finished = 1'b0;
        chk1("done_pulse", done, 1'b0);
        chk1("busy_flush", busy, 1'b1);
        chk1("we_flush", rf_we, 1'b0);
        tick();
        chk1("busy_idle", busy, 1'b0);
        chk1("err_idle", err, 1'b0);
        chk32("wdata_hold", rf_wdata, res);
    endtask

    initial begin
        clrn             = 1'b0;
        start            = 1'b0;
        rt_addr          = 5'd0;
        rd_addr          = 5'd0;
        eu.exec_finished = 1'b0;
        eu.exec_res      = 32'd0;
        eu.exec_dst_type = DST_NONE;

        repeat (2) @(posedge clk);
        #1;
        chk1("rst_exec_en", eu.exec_en, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_err", err, 1'b0);
        chk1("rst_rf_we", rf_we, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk32("rst_waddr", {27'd0, rf_waddr}, 32'd0);
        chk32("rst_wdata", rf_wdata, 32'd0);
        #2 clrn = 1'b1;
        tick();

        do_instr(5'd3, 5'd5, 1, 32'h0000_000C, DST_RD);
        do_instr(5'd4, 5'd0, 1, 32'hFFFF_FFFF, DST_RD);
        do_instr(5'd2, 5'd6, 10, 32'h0040_0008, DST_RA);
        do_instr(5'd9, 5'd1, 3, 32'hDEAD_BEEF, DST_RT);
        do_instr(5'd7, 5'd8, 2, 32'h1234_5678, DST_NONE);

        // start held through EXEC and FLUSH; finished lingers 3 cycles after en drops
        $display("INSTR start-while-busy rd=7");
        sb_q.push_back(expect_wb(5'd1, 5'd7, 32'h0000_0055, DST_RD));
        rt_addr = 5'd1;
        rd_addr = 5'd7;
        start   = 1'b1;
        tick();
        rt_addr = 5'd2;
        rd_addr = 5'd9;
        chk1("sb_en_c1", eu.exec_en, 1'b1);
        tick();
        eu.exec_finished = 1'b1;
        eu.exec_res      = 32'h0000_0055;
        eu.exec_dst_type = DST_RD;
        chk1("sb_en_c2", eu.exec_en, 1'b1);
        tick();
        chk1("sb_done_wb", done, 1'b1);
        chk1("sb_en_wb", eu.exec_en, 1'b0);
        tick();
        for (int i = 0; i < 2; i++) begin
            chk1("sb_flush_busy", busy, 1'b1);
            chk1("sb_flush_en", eu.exec_en, 1'b0);
            chk1("sb_flush_done", done, 1'b0);
            tick();
        end
        eu.exec_finished = 1'b0;
        chk1("sb_flush_last", busy, 1'b1);
        tick();
        start = 1'b0;
        chk1("sb_idle_busy", busy, 1'b0);
        chk1("sb_idle_en", eu.exec_en, 1'b0);
        tick();
        chk1("sb_no_second", busy, 1'b0);

        // asynchronous reset in the middle of EXEC abandons the instruction
        $display("INSTR abandoned-by-reset rt=3 rd=4");
        rt_addr = 5'd3;
        rd_addr = 5'd4;
        start   = 1'b1;
        tick();
        start = 1'b0;
        eu.exec_res      = 32'h0BAD_0BAD;
        eu.exec_dst_type = DST_RD;
        tick();
        tick();
        chk1("ar_en_before", eu.exec_en, 1'b1);
        #2 clrn = 1'b0;
        #1;
        chk1("ar_en_now", eu.exec_en, 1'b0);
        chk1("ar_busy_now", busy, 1'b0);
        chk1("ar_we_now", rf_we, 1'b0);
        #2 clrn = 1'b1;
        tick();
        chk1("ar_idle", busy, 1'b0);
        do_instr(5'd3, 5'd4, 1, 32'h0000_A5A5, DST_RD);

        // watchdog: the unit never finishes
        $display("INSTR timeout rt=5 rd=6");
        rt_addr = 5'd5;
        rd_addr = 5'd6;
        start   = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 64; i++) begin
            chk1("to_en", eu.exec_en, 1'b1);
            chk1("to_err_early", err, 1'b0);
            tick();
        end
        chk1("to_err", err, 1'b1);
        chk1("to_en_off", eu.exec_en, 1'b0);
        chk1("to_busy", busy, 1'b1);
        start = 1'b1;
        tick();
        tick();
        start = 1'b0;
        chk1("to_err_hold", err, 1'b1);
        chk1("to_busy_hold", busy, 1'b1);
        chk1("to_en_hold", eu.exec_en, 1'b0);
        #2 clrn = 1'b0;
        #1;
        chk1("to_rst_err", err, 1'b0);
        chk1("to_rst_busy", busy, 1'b0);
        #2 clrn = 1'b1;
        tick();
        chk1("to_idle", busy, 1'b0);
        do_instr(5'd1, 5'd2, 1, 32'h0000_0077, DST_RT);

        chk32("sb_drained", sb_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
